status_flags_reg: RTL

Parametrised ALU status-flag register and the successor to the single zero-flag register. It captures Zero, Negative, Carry, Overflow and optional extra flags, with a per-bit update mask. It evaluates a selected branch condition for the conditional-jump logic (JMPZ, JMPNZ, JMPC, …). An optional LIFO shadow stack saves and restores the flags across calls and interrupts. It sits between the ALU flag outputs and the program-counter branch logic in the core.

---
 rtl/flags_pkg.sv | 22 ++
 rtl/flag_stack.sv | 79 +++++++
 rtl/status_flags_reg.sv | 106 ++++++++++
 3 files changed

// File: rtl/flags_pkg.sv
// Shared definitions for the ALU status-flag register.
//   FLAG_Z/N/C/V : bit positions of the architectural flags in the flag vector
//   cond_e       : branch-condition select encoding used by cond_sel
package flags_pkg;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

    typedef enum logic [2:0] {
        ALWAYS = 3'd0,
        Z      = 3'd1,
        NZ     = 3'd2,
        C      = 3'd3,
        NC     = 3'd4,
        N      = 3'd5,
        V      = 3'd6,
        NEVER  = 3'd7
    } cond_e;

endpackage

// File: rtl/flag_stack.sv
// Parametrised LIFO used to save and restore the flag register.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   push, pop         : single-cycle strobes; both together is a no-op
//   err_clr           : clears the sticky error (a same-cycle new error wins)
//   wdata             : value written on an accepted push
//   rdata             : top-of-stack entry, valid while not empty
//   pop_ok            : combinational, an accepted pop happens this cycle
//   full, empty, err  : pointer-decoded status and sticky over/underflow error
module flag_stack #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             err_clr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             pop_ok,
    output logic             full,
    output logic             empty,
    output logic             err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    ptr_q, ptr_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             push_only, pop_only, do_push, do_pop;
    logic [AW-1:0]    wr_idx, rd_idx;

    // Pointer counts entries (0..DEPTH), so full/empty decode directly from it.
    assign full  = (ptr_q == PW'(DEPTH));
    assign empty = (ptr_q == '0);
    assign err   = err_q;

    // Pointer, error and access decode.
    always_comb begin
        push_only = push & ~pop;
        pop_only  = pop & ~push;
        do_push   = push_only & ~full;
        do_pop    = pop_only & ~empty;
        wr_idx    = ptr_q[AW-1:0];
        rd_idx    = AW'(ptr_q - PW'(1));
        ptr_d     = ptr_q;
        if (do_push) begin
            ptr_d = ptr_q + PW'(1);
        end else if (do_pop) begin
            ptr_d = ptr_q - PW'(1);
        end
        err_d  = (err_q & ~err_clr) | (push_only & full) | (pop_only & empty);
        pop_ok = do_pop;
        rdata  = mem_q[rd_idx];
    end

    // Pointer and error state.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (do_push && !reset) begin
            mem_q[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/status_flags_reg.sv
// ALU status-flag register with per-bit update mask, branch-condition
// evaluation and an optional shadow stack (enabled by macro FLAG_STACK_EN).
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   flags_in      : flag values from the ALU
//   flags_we      : update enable; flags_mask selects which bits update
//   cond_sel      : cond_e condition select
//   cond_true     : combinational evaluation of cond_sel on flags_out
//   flags_out     : registered flags (bit0 Z, bit1 N, bit2 C, bit3 V)
//   push, pop     : save/restore flags_out via the shadow stack
//   stack_full/stack_empty/stack_err : stack status, err is sticky
//   err_clr       : clears stack_err
// Without FLAG_STACK_EN the stack is absent, push/pop/err_clr are ignored and
// the stack status outputs are constant (empty=1, full=0, err=0).
module status_flags_reg
    import flags_pkg::*;
#(
    parameter int unsigned N_FLAGS     = 4,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_FLAGS-1:0] flags_in,
    input  logic               flags_we,
    input  logic [N_FLAGS-1:0] flags_mask,
    input  logic [2:0]         cond_sel,
    output logic               cond_true,
    output logic [N_FLAGS-1:0] flags_out,
    input  logic               push,
    input  logic               pop,
    output logic               stack_full,
    output logic               stack_empty,
    output logic               stack_err,
    input  logic               err_clr
);

    logic [N_FLAGS-1:0] flags_q, flags_d;
    logic               pop_load;
    logic [N_FLAGS-1:0] pop_data;

`ifdef FLAG_STACK_EN
    flag_stack #(
        .WIDTH (N_FLAGS),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .err_clr (err_clr),
        .wdata   (flags_q),
        .rdata   (pop_data),
        .pop_ok  (pop_load),
        .full    (stack_full),
        .empty   (stack_empty),
        .err     (stack_err)
    );
`else
    logic unused_stack_inputs;

    assign pop_load            = 1'b0;
    assign pop_data            = '0;
    assign stack_full          = 1'b0;
    assign stack_empty         = 1'b1;
    assign stack_err           = 1'b0;
    assign unused_stack_inputs = ^{push, pop, err_clr, 1'(STACK_DEPTH & 1)};
`endif

    // A successful pop restores every bit and discards any same-cycle update.
    always_comb begin
        flags_d = flags_q;
        if (pop_load) begin
            flags_d = pop_data;
        end else if (flags_we) begin
            flags_d = (flags_q & ~flags_mask) | (flags_in & flags_mask);
        end
    end

    // Flag register.
    always_ff @(posedge clock) begin
        if (reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags_out = flags_q;

    // Branch-condition multiplexer on the registered flags.
    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond_sel))
            ALWAYS:  cond_true = 1'b1;
            Z:       cond_true = flags_q[FLAG_Z];
            NZ:      cond_true = ~flags_q[FLAG_Z];
            C:       cond_true = flags_q[FLAG_C];
            NC:      cond_true = ~flags_q[FLAG_C];
            N:       cond_true = flags_q[FLAG_N];
            V:       cond_true = flags_q[FLAG_V];
            NEVER:   cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule
